// File: rtl/mem_load_ctrl_if.sv
// mem_load_ctrl_if: stream, compute and mem_sys
// signals around the load controller
interface mem_load_ctrl_if #(
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int W_SEL_LEN  = 2,
  parameter int X_SEL_LEN  = 2
);
  logic                  start;
  logic                  in_valid;
  logic                  in_data;
  logic                  in_ready;
  logic                  busy;
  logic                  load_done;
  logic                  cmp_rd_w;
  logic [W_ADDR_LEN-1:0] cmp_addr_w;
  logic [W_SEL_LEN-1:0]  cmp_sel_w;
  logic                  cmp_rd_x;
  logic [X_ADDR_LEN-1:0] cmp_addr_x;
  logic [X_SEL_LEN-1:0]  cmp_sel_x;
  logic                  cmp_valid_w;
  logic                  cmp_data_w;
  logic                  cmp_valid_x;
  logic                  cmp_data_x;
  logic                  we_w;
  logic                  we_x;
  logic [W_ADDR_LEN-1:0] address_w;
  logic [X_ADDR_LEN-1:0] address_x;
  logic [W_SEL_LEN-1:0]  sel_w;
  logic [X_SEL_LEN-1:0]  sel_x;
  logic                  data_in;
  logic                  data_out_w;
  logic                  data_out_x;

  modport master (
    output start, in_valid, in_data,
    output cmp_rd_w, cmp_addr_w, cmp_sel_w,
    output cmp_rd_x, cmp_addr_x, cmp_sel_x,
    output data_out_w, data_out_x,
    input  in_ready, busy, load_done,
    input  cmp_valid_w, cmp_data_w,
    input  cmp_valid_x, cmp_data_x,
    input  we_w, we_x, address_w, address_x,
    input  sel_w, sel_x, data_in
  );

  modport slave (
    input  start, in_valid, in_data,
    input  cmp_rd_w, cmp_addr_w, cmp_sel_w,
    input  cmp_rd_x, cmp_addr_x, cmp_sel_x,
    input  data_out_w, data_out_x,
    output in_ready, busy, load_done,
    output cmp_valid_w, cmp_data_w,
    output cmp_valid_x, cmp_data_x,
    output we_w, we_x, address_w, address_x,
    output sel_w, sel_x, data_in
  );
endinterface

// File: rtl/mem_load_ctrl.sv
// mem_load_ctrl: loads a serial stream into mem_sys
// banks, then hands the read ports to compute
module mem_load_ctrl #(
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int W_SEL_LEN  = 2,
  parameter int X_SEL_LEN  = 2,
  parameter int W1_LEN     = 10,
  parameter int W2_LEN     = 10,
  parameter int W3_LEN     = 10,
  parameter int W4_LEN     = 10,
  parameter int X_LEN      = 8
) (
  input logic            clk,
  input logic            rst,
  mem_load_ctrl_if.slave bus
);
  localparam int CW = (W_ADDR_LEN > X_ADDR_LEN) ?
                      W_ADDR_LEN : X_ADDR_LEN;

  typedef enum logic [1:0] {
    IDLE, LOAD_W, LOAD_X, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            bank_q, bank_d;
  logic [CW-1:0]         addr_q, addr_d;
  logic [CW-1:0]         last_addr;
  logic [W_ADDR_LEN-1:0] wa_q, wa_d;
  logic [W_SEL_LEN-1:0]  ws_q, ws_d;
  logic [X_ADDR_LEN-1:0] xa_q, xa_d;
  logic [X_SEL_LEN-1:0]  xs_q, xs_d;
  logic                  din_q, din_d;
  logic                  we_w_q, we_w_d;
  logic                  we_x_q, we_x_d;
  logic                  pend_w_q, pend_w_d;
  logic                  pend_x_q, pend_x_d;
  logic                  vld_w_q, vld_w_d;
  logic                  vld_x_q, vld_x_d;
  logic                  dat_w_q, dat_w_d;
  logic                  dat_x_q, dat_x_d;
  logic                  loading;

  assign loading = (state_q == LOAD_W) ||
                   (state_q == LOAD_X);

  // last word address of the bank being filled
  always_comb begin
    last_addr = CW'(X_LEN - 1);
    unique case (bank_q)
      3'd0:    last_addr = CW'(W1_LEN - 1);
      3'd1:    last_addr = CW'(W2_LEN - 1);
      3'd2:    last_addr = CW'(W3_LEN - 1);
      3'd3:    last_addr = CW'(W4_LEN - 1);
      default: last_addr = CW'(X_LEN - 1);
    endcase
  end

  // load FSM, counters and registered write port
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    wa_d    = wa_q;
    ws_d    = ws_q;
    xa_d    = xa_q;
    xs_d    = xs_q;
    din_d   = din_q;
    we_w_d  = 1'b0;
    we_x_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = LOAD_W;
          bank_d  = '0;
          addr_d  = '0;
        end
      end
      LOAD_W: begin
        if (bus.in_valid) begin
          we_w_d = 1'b1;
          wa_d   = W_ADDR_LEN'(addr_q);
          ws_d   = W_SEL_LEN'(bank_q);
          din_d  = bus.in_data;
          if (addr_q == last_addr) begin
            addr_d = '0;
            bank_d = bank_q + 3'd1;
            if (bank_q == 3'd3) state_d = LOAD_X;
          end else begin
            addr_d = addr_q + CW'(1);
          end
        end
      end
      LOAD_X: begin
        if (bus.in_valid) begin
          we_x_d = 1'b1;
          xa_d   = X_ADDR_LEN'(addr_q);
          xs_d   = '0;
          din_d  = bus.in_data;
          if (addr_q == last_addr) begin
            addr_d  = '0;
            state_d = DONE;
          end else begin
            addr_d = addr_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // compute reads: accept, wait out mem latency, flag
  always_comb begin
    pend_w_d = ~loading & bus.cmp_rd_w;
    pend_x_d = ~loading & bus.cmp_rd_x;
    vld_w_d  = pend_w_q;
    vld_x_d  = pend_x_q;
    dat_w_d  = pend_w_q ? bus.data_out_w : dat_w_q;
    dat_x_d  = pend_x_q ? bus.data_out_x : dat_x_q;
  end

  // state and pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bank_q   <= '0;
      addr_q   <= '0;
      wa_q     <= '0;
      ws_q     <= '0;
      xa_q     <= '0;
      xs_q     <= '0;
      din_q    <= 1'b0;
      we_w_q   <= 1'b0;
      we_x_q   <= 1'b0;
      pend_w_q <= 1'b0;
      pend_x_q <= 1'b0;
      vld_w_q  <= 1'b0;
      vld_x_q  <= 1'b0;
      dat_w_q  <= 1'b0;
      dat_x_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      addr_q   <= addr_d;
      wa_q     <= wa_d;
      ws_q     <= ws_d;
      xa_q     <= xa_d;
      xs_q     <= xs_d;
      din_q    <= din_d;
      we_w_q   <= we_w_d;
      we_x_q   <= we_x_d;
      pend_w_q <= pend_w_d;
      pend_x_q <= pend_x_d;
      vld_w_q  <= vld_w_d;
      vld_x_q  <= vld_x_d;
      dat_w_q  <= dat_w_d;
      dat_x_q  <= dat_x_d;
    end
  end

  // the final write lands in DONE, so a pending
  // write keeps the port until it has issued
  assign bus.in_ready    = loading;
  assign bus.busy        = loading;
  assign bus.load_done   = (state_q == DONE);
  assign bus.we_w        = we_w_q;
  assign bus.we_x        = we_x_q;
  assign bus.data_in     = din_q;
  assign bus.address_w   = (loading | we_w_q) ?
                           wa_q : bus.cmp_addr_w;
  assign bus.sel_w       = (loading | we_w_q) ?
                           ws_q : bus.cmp_sel_w;
  assign bus.address_x   = (loading | we_x_q) ?
                           xa_q : bus.cmp_addr_x;
  assign bus.sel_x       = (loading | we_x_q) ?
                           xs_q : bus.cmp_sel_x;
  assign bus.cmp_valid_w = vld_w_q;
  assign bus.cmp_valid_x = vld_x_q;
  assign bus.cmp_data_w  = dat_w_q;
  assign bus.cmp_data_x  = dat_x_q;
endmodule

// File: tb/tb_mem_load_ctrl.sv
// tb_mem_load_ctrl: stream loads, compute reads,
// abort and reload against a reference model
`timescale 1ns/1ps
module tb_mem_load_ctrl;
  localparam int WA  = 20;
  localparam int XA  = 10;
  localparam int WS  = 2;
  localparam int XS  = 2;
  localparam int L0  = 10;
  localparam int L1  = 10;
  localparam int L2  = 10;
  localparam int L3  = 10;
  localparam int LX  = 8;
  localparam int TOT = L0 + L1 + L2 + L3 + LX;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;

  mem_load_ctrl_if #(
    .W_ADDR_LEN(WA), .X_ADDR_LEN(XA),
    .W_SEL_LEN(WS), .X_SEL_LEN(XS)
  ) bus ();

  mem_load_ctrl #(
    .W_ADDR_LEN(WA), .X_ADDR_LEN(XA),
    .W_SEL_LEN(WS), .X_SEL_LEN(XS),
    .W1_LEN(L0), .W2_LEN(L1), .W3_LEN(L2),
    .W4_LEN(L3), .X_LEN(LX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mem_sys stand-in: sync write, 1-cycle sync read
  logic mw [4][16];
  logic mx [4][16];
  always @(posedge clk) begin
    if (bus.we_w)
      mw[bus.sel_w][bus.address_w[3:0]] <= bus.data_in;
    if (bus.we_x)
      mx[bus.sel_x][bus.address_x[3:0]] <= bus.data_in;
    bus.data_out_w <= mw[bus.sel_w][bus.address_w[3:0]];
    bus.data_out_x <= mx[bus.sel_x][bus.address_x[3:0]];
  end

  logic stream [TOT];

  function automatic void map_idx(input int n,
                                  output logic is_x,
                                  output int sel,
                                  output int addr);
    int lens [5];
    int r;
    lens = '{L0, L1, L2, L3, LX};
    r = n;
    sel = 0;
    while (sel < 4 && r >= lens[sel]) begin
      r -= lens[sel];
      sel++;
    end
    is_x = (sel == 4);
    addr = r;
    if (is_x) sel = 0;
  endfunction

  // reference: phase + handshake count
  int   m_phase = 0;
  int   m_n = 0;
  logic e_we_w = 0, e_we_x = 0, e_din = 0;
  logic p_w = 0, p_x = 0, e_vw = 0, e_vx = 0;
  logic e_dw = 0, e_dx = 0;
  int   e_wa = 0, e_ws = 0, e_xa = 0, e_xs = 0;

  task automatic model_step();
    logic ld, isx;
    int   s, a;
    if (!rst) begin
      m_phase = 0; m_n = 0;
      e_we_w = 0; e_we_x = 0; e_din = 0;
      p_w = 0; p_x = 0; e_vw = 0; e_vx = 0;
      e_dw = 0; e_dx = 0;
      e_wa = 0; e_ws = 0; e_xa = 0; e_xs = 0;
    end else begin
      ld = (m_phase == 1);
      e_vw = p_w;
      if (p_w) e_dw = bus.data_out_w;
      e_vx = p_x;
      if (p_x) e_dx = bus.data_out_x;
      p_w = !ld && bus.cmp_rd_w;
      p_x = !ld && bus.cmp_rd_x;
      e_we_w = 0;
      e_we_x = 0;
      if (ld && bus.in_valid) begin
        map_idx(m_n, isx, s, a);
        if (isx) begin
          e_we_x = 1; e_xa = a; e_xs = s;
        end else begin
          e_we_w = 1; e_wa = a; e_ws = s;
        end
        e_din = bus.in_data;
        m_n++;
        if (m_n == TOT) m_phase = 2;
      end else if (!ld && bus.start) begin
        m_phase = 1;
        m_n = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  typedef struct {
    logic is_x; int sel; int addr; logic d;
  } wr_t;
  wr_t  wlog [$];
  logic rq_w [$];
  logic rq_x [$];

  // cycle check against the model, plus logging
  initial forever begin
    logic ld;
    int ew, es, ex, exs;
    @(negedge clk);
    ld  = (m_phase == 1);
    ew  = (ld || e_we_w) ? e_wa : int'(bus.cmp_addr_w);
    es  = (ld || e_we_w) ? e_ws : int'(bus.cmp_sel_w);
    ex  = (ld || e_we_x) ? e_xa : int'(bus.cmp_addr_x);
    exs = (ld || e_we_x) ? e_xs : int'(bus.cmp_sel_x);
    chk("ctrl",
        {bus.in_ready, bus.busy, bus.load_done,
         bus.we_w, bus.we_x, bus.data_in,
         bus.cmp_valid_w, bus.cmp_valid_x},
        {ld, ld, m_phase == 2, e_we_w, e_we_x,
         e_din, e_vw, e_vx});
    chk("addr_w", 32'(bus.address_w), ew);
    chk("sel_w", 32'(bus.sel_w), es);
    chk("addr_x", 32'(bus.address_x), ex);
    chk("sel_x", 32'(bus.sel_x), exs);
    if (e_vw) chk("rdata_w", bus.cmp_data_w, e_dw);
    if (e_vx) chk("rdata_x", bus.cmp_data_x, e_dx);
    if (bus.we_w)
      wlog.push_back(wr_t'{1'b0, int'(bus.sel_w),
                           int'(bus.address_w), bus.data_in});
    if (bus.we_x)
      wlog.push_back(wr_t'{1'b1, int'(bus.sel_x),
                           int'(bus.address_x), bus.data_in});
    if (bus.cmp_valid_w) rq_w.push_back(bus.cmp_data_w);
    if (bus.cmp_valid_x) rq_x.push_back(bus.cmp_data_x);
  end

  typedef struct {
    int idx; logic is_x; int sel; int addr;
  } vec_t;
  vec_t tbl [8];

  task automatic check_log();
    int bad;
    chk("log_len", wlog.size(), TOT);
    if (wlog.size() == TOT) begin
      for (int i = 0; i < 8; i++) begin
        chk("wr_kind", wlog[tbl[i].idx].is_x, tbl[i].is_x);
        chk("wr_sel", wlog[tbl[i].idx].sel, tbl[i].sel);
        chk("wr_addr", wlog[tbl[i].idx].addr, tbl[i].addr);
      end
      bad = 0;
      for (int i = 0; i < TOT; i++)
        if (wlog[i].d !== stream[i]) bad++;
      chk("wr_data", bad, 0);
    end
  endtask

  task automatic clr_cmp();
    bus.cmp_rd_w = 0; bus.cmp_addr_w = '0;
    bus.cmp_sel_w = '0;
    bus.cmp_rd_x = 0; bus.cmp_addr_x = '0;
    bus.cmp_sel_x = '0;
  endtask

  task automatic rand_cmp();
    bus.cmp_rd_w   = 1'($urandom);
    bus.cmp_addr_w = WA'($urandom_range(0, 15));
    bus.cmp_sel_w  = WS'($urandom);
    bus.cmp_rd_x   = 1'($urandom);
    bus.cmp_addr_x = XA'($urandom_range(0, 15));
    bus.cmp_sel_x  = XS'($urandom);
  endtask

  // mode 0: valid always, 1: toggling, 2: random
  task automatic run_load(input int mode,
                          input int abort_at);
    int   k, cyc;
    logic v;
    k = 0;
    cyc = 0;
    foreach (stream[i]) stream[i] = 1'($urandom);
    wlog.delete();
    rq_w.delete();
    bus.start = 1;
    tick();
    bus.start = 0;
    chk("start_ack",
        {bus.load_done, bus.in_ready, bus.busy}, 3'b011);
    while (k < TOT && cyc < 1000) begin
      v = (mode == 0) ? 1'b1 :
          (mode == 1) ? (cyc % 2 == 0) : 1'($urandom);
      bus.in_valid = v;
      bus.in_data = stream[k];
      if (mode == 2) begin
        rand_cmp();
        bus.start = ($urandom_range(0, 7) == 0);
      end
      tick();
      if (v) k++;
      cyc++;
      if (k == abort_at) begin
        bus.in_valid = 0;
        bus.start = 0;
        clr_cmp();
        @(negedge clk);
        #1 rst = 0;
        #1;
        chk("abort_zero",
            {bus.in_ready, bus.busy, bus.load_done,
             bus.cmp_valid_w, bus.cmp_data_w,
             bus.cmp_valid_x, bus.cmp_data_x,
             bus.we_w, bus.we_x, bus.data_in,
             bus.sel_w, bus.sel_x,
             |bus.address_w, |bus.address_x}, 0);
        repeat (3) tick();
        chk("abort_log", wlog.size(), abort_at);
        rst = 1;
        tick();
        return;
      end
    end
    bus.in_valid = 0;
    bus.start = 0;
    clr_cmp();
    chk("load_bound", k, TOT);
    chk("load_rd_w", rq_w.size(), 0);
    @(negedge clk);
    chk("done_lvl",
        {bus.load_done, bus.busy, bus.we_x}, 3'b101);
    tick();
    tick();
    check_log();
  endtask

  task automatic reads();
    rq_w.delete();
    rq_x.delete();
    for (int a = 0; a < 10; a++) begin
      bus.cmp_rd_w = 1;
      bus.cmp_sel_w = 2'd2;
      bus.cmp_addr_w = WA'(a);
      bus.cmp_rd_x = (a == 0);
      bus.cmp_sel_x = '0;
      bus.cmp_addr_x = XA'(3);
      tick();
    end
    clr_cmp();
    repeat (3) tick();
    chk("rd_w_cnt", rq_w.size(), 10);
    if (rq_w.size() == 10)
      for (int a = 0; a < 10; a++)
        chk("rd_w_data", rq_w[a], stream[L0 + L1 + a]);
    chk("rd_x_cnt", rq_x.size(), 1);
    if (rq_x.size() == 1)
      chk("rd_x_data", rq_x[0], stream[L0 + L1 + L2 + L3 + 3]);
  endtask

  initial begin
    tbl = '{
      vec_t'{0,  1'b0, 0, 0}, vec_t'{9,  1'b0, 0, 9},
      vec_t'{10, 1'b0, 1, 0}, vec_t'{19, 1'b0, 1, 9},
      vec_t'{29, 1'b0, 2, 9}, vec_t'{39, 1'b0, 3, 9},
      vec_t'{40, 1'b1, 0, 0}, vec_t'{47, 1'b1, 0, 7}
    };
    bus.start = 0;
    bus.in_valid = 0;
    bus.in_data = 0;
    clr_cmp();
    repeat (2) @(negedge clk);
    chk("reset_outs",
        {bus.in_ready, bus.busy, bus.load_done,
         bus.cmp_valid_w, bus.cmp_valid_x,
         bus.we_w, bus.we_x, bus.data_in,
         bus.sel_w, bus.sel_x,
         |bus.address_w, |bus.address_x}, 0);
    tick();
    rst = 1;
    tick();
    run_load(0, -1);
    reads();
    for (int i = 0; i < 60; i++) begin
      rand_cmp();
      tick();
    end
    clr_cmp();
    tick();
    tick();
    run_load(1, -1);
    tick();
    run_load(2, -1);
    tick();
    run_load(0, 15);
    run_load(0, -1);
    reads();
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
